// File: rtl/xor_stream_accum_pkg.sv
// ============================================================================
// Module   : xor_stream_pkg
// Brief    : Shared FSM encoding, default sizes and saturating-increment helper
//            for the XOR stream accumulator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package xor_stream_pkg;

  localparam int C_DEFAULT_WIDTH = 8;
  localparam int C_DEFAULT_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Counts up to max and then sticks there; widths up to 31 bits are covered.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic [31:0] max);
    return (cnt >= max) ? max : cnt + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/xor_sat_counter.sv
// ============================================================================
// Module   : xor_sat_counter
// Brief    : CNT_W-bit saturating word counter with clear / load-1 / increment.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module xor_sat_counter
  import xor_stream_pkg::*;
#(
  parameter int CNT_W = C_DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_load1,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  localparam logic [31:0] c_max = 32'((64'd1 << CNT_W) - 64'd1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_inc_val;

  assign w_inc_val = CNT_W'(sat_inc(32'(r_cnt), c_max));

  // Clear wins over load, load wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load1) begin
      r_cnt <= CNT_W'(1);
    end else if (i_inc) begin
      r_cnt <= w_inc_val;
    end
  end

  assign o_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/xor_stream_accum.sv
// ============================================================================
// Module   : xor_stream_accum
// Brief    : Framed valid/ready XOR checksum accumulator with saturating length.
//            Optional check-word error flag built when XOR_CHECK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module xor_stream_accum
  import xor_stream_pkg::*;
#(
  parameter int WIDTH = C_DEFAULT_WIDTH,
  parameter int CNT_W = C_DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_xor,
  output logic [CNT_W-1:0] out_len,
  output logic             out_err
);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0] r_out_xor;
  logic             r_out_valid;
  logic             w_beat;
  logic             w_last_beat;
  logic             w_handoff;

  // Held low during reset even though the state register already reads IDLE.
  assign in_ready    = ~rst & (r_state != ST_DONE);
  assign w_beat      = in_valid & in_ready;
  assign w_last_beat = w_beat & in_last;
  assign w_handoff   = r_out_valid & out_ready;
  assign w_acc_next  = (r_state == ST_IDLE) ? in_data : (r_acc ^ in_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_beat) begin
          w_state_next = in_last ? ST_DONE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (w_last_beat) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_out_xor   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_beat) begin
        r_acc <= w_acc_next;
      end
      if (w_last_beat) begin
        r_out_xor   <= w_acc_next;
        r_out_valid <= 1'b1;
      end else if (w_handoff) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // The counter only moves on beats, so it holds the frame length through DONE.
  xor_sat_counter #(
    .CNT_W (CNT_W)
  ) u_len_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_handoff),
    .i_load1 (w_beat & (r_state == ST_IDLE)),
    .i_inc   (w_beat & (r_state == ST_ACCUM)),
    .o_cnt   (out_len)
  );

`ifdef XOR_CHECK_EN
  logic r_out_err;

  // The check word is folded in, so a clean frame XORs to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_err <= 1'b0;
    end else if (w_last_beat) begin
      r_out_err <= (w_acc_next != '0);
    end
  end

  assign out_err = r_out_err;
`else
  assign out_err = 1'b0;
`endif

  assign out_valid = r_out_valid;
  assign out_xor   = r_out_xor;

endmodule

`default_nettype wire

// File: tb/tb_xor_stream_accum.sv
// ============================================================================
// Module   : tb_xor_stream_accum
// Brief    : Directed self-checking bench for xor_stream_accum (CNT_W=8 and 3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xor_stream_accum;

`ifdef XOR_CHECK_EN
  localparam bit c_chk = 1'b1;
`else
  localparam bit c_chk = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b1;

  logic       in_ready, out_valid, out_err;
  logic [7:0] out_xor, out_len;
  logic       in_ready3, out_valid3, out_err3;
  logic [7:0] out_xor3;
  logic [2:0] out_len3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xor_stream_accum #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_xor(out_xor), .out_len(out_len), .out_err(out_err)
  );

  xor_stream_accum #(.WIDTH(8), .CNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid3),
    .out_ready(out_ready), .out_xor(out_xor3), .out_len(out_len3), .out_err(out_err3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_result(input string name, input logic [7:0] x, input logic [7:0] l,
                              input logic e);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s out_valid: got %b expected 1", name, out_valid);
    end
    checks++;
    if (out_xor !== x) begin
      errors++;
      $display("FAIL %s out_xor: got %h expected %h", name, out_xor, x);
    end
    checks++;
    if (out_len !== l) begin
      errors++;
      $display("FAIL %s out_len: got %0d expected %0d", name, out_len, l);
    end
    checks++;
    if (out_err !== e) begin
      errors++;
      $display("FAIL %s out_err: got %b expected %b", name, out_err, e);
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s idle: got valid=%b ready=%b expected valid=0 ready=1",
               name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    step();
    checks++;
    if ({in_ready, out_valid, out_xor, out_len, out_err} !== 19'd0) begin
      errors++;
      $display("FAIL reset: got ready=%b valid=%b xor=%h len=%0d err=%b expected all 0",
               in_ready, out_valid, out_xor, out_len, out_err);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    step();
    check_idle("reset_release");
  endtask

  task automatic test_multi_word();
    out_ready = 1'b1;
    send(8'h0F, 1'b0);
    send(8'hF0, 1'b0);
    send(8'h3C, 1'b1);
    check_result("multi", 8'hC3, 8'd3, c_chk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL multi in_ready: got %b expected 0", in_ready);
    end
    step();
    check_idle("multi_after");
  endtask

  task automatic test_single();
    send(8'hA5, 1'b1);
    check_result("single", 8'hA5, 8'd1, c_chk);
    step();
    check_idle("single_after");
  endtask

  task automatic test_bubble();
    send(8'h01, 1'b0);
    in_last = 1'b1;   // last without valid must be ignored
    step();
    in_last = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bubble early valid: got %b expected 0", out_valid);
    end
    send(8'h80, 1'b1);
    check_result("bubble", 8'h81, 8'd2, c_chk);
    step();
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    send(8'h01, 1'b0);
    send(8'h02, 1'b1);
    in_valid = 1'b1;
    in_data  = 8'h55;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp in_ready cycle %0d: got %b expected 0", i, in_ready);
      end
      check_result("bp_hold", 8'h03, 8'd2, c_chk);
      step();
    end
    out_ready = 1'b1;
    #1;
    check_result("bp_pre_handoff", 8'h03, 8'd2, c_chk);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_idle("bp_handoff");
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 9; i++) begin
      send(8'hFF, (i == 8));
    end
    check_result("sat8", 8'hFF, 8'd9, 1'b1 & c_chk);
    checks++;
    if (out_valid3 !== 1'b1 || out_xor3 !== 8'hFF || out_len3 !== 3'd7) begin
      errors++;
      $display("FAIL sat3: got valid=%b xor=%h len=%0d expected 1 ff 7",
               out_valid3, out_xor3, out_len3);
    end
    step();
  endtask

  task automatic test_reset_mid_frame();
    send(8'h11, 1'b0);
    send(8'h11, 1'b0);
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, out_xor, out_len, out_err} !== 19'd0) begin
      errors++;
      $display("FAIL rst_mid: got ready=%b valid=%b xor=%h len=%0d err=%b expected all 0",
               in_ready, out_valid, out_xor, out_len, out_err);
    end
    step();
    rst = 1'b0;
    step();
    send(8'h22, 1'b1);
    check_result("rst_mid_next", 8'h22, 8'd1, c_chk);
    step();
  endtask

  task automatic test_check_word();
    send(8'h12, 1'b0);
    send(8'h34, 1'b0);
    send(8'h26, 1'b1);
    check_result("chk_good", 8'h00, 8'd3, 1'b0);
    step();
    send(8'h12, 1'b0);
    send(8'h34, 1'b0);
    send(8'h27, 1'b1);
    check_result("chk_bad", 8'h01, 8'd3, c_chk);
    step();
    check_idle("chk_after");
  endtask

  initial begin
    test_reset();
    test_multi_word();
    test_single();
    test_bubble();
    test_back_pressure();
    test_saturate();
    test_reset_mid_frame();
    test_check_word();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
